// File: rtl/jam_pkg.sv
// Shared definitions for the job-assignment engine: matrix geometry,
// cost/bound widths, the cost-buffer state type and the W/J index type.
package jam_pkg;
   localparam int ROWS   = 8;
   localparam int COST_W = 7;
   localparam int LB_W   = 10;
   localparam int ADDR_W = 6;

   typedef logic [2:0] idx_t;

   typedef enum logic {
      LOAD  = 1'b0,
      SERVE = 1'b1
   } state_t;
endpackage

// File: rtl/jam_row_min_acc.sv
// Tracks the running minimum of the current row and adds it to the
// lower-bound accumulator when the row's last column is accepted.
module jam_row_min_acc
   import jam_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              accept,
   input  idx_t              col,
   input  logic [COST_W-1:0] data,
   input  logic              clear,
   output logic [LB_W-1:0]   lb
);

   logic [COST_W-1:0] row_min_q, row_min_d;
   logic [LB_W-1:0]   lb_q, lb_d;
   logic [COST_W-1:0] min_val;

   assign min_val = (data < row_min_q) ? data : row_min_q;

   always_comb begin
      row_min_d = row_min_q;
      lb_d      = lb_q;
      if (clear) begin
         row_min_d = '0;
         lb_d      = '0;
      end else if (accept) begin
         // Column 0 starts a fresh row, so the stale minimum is ignored.
         row_min_d = (col == idx_t'(0)) ? data : min_val;
         if (col == idx_t'(ROWS - 1))
            lb_d = lb_q + LB_W'(min_val);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         row_min_q <= '0;
         lb_q      <= '0;
      end else begin
         row_min_q <= row_min_d;
         lb_q      <= lb_d;
      end
   end

   assign lb = lb_q;

endmodule

// File: rtl/jam_cost_buffer.sv
// Cost-matrix front end: streams in the 8x8 cost table, serves combinational
// W/J lookups and accumulates the sum of row minimums during the load.
module jam_cost_buffer
   import jam_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [COST_W-1:0] in_data,
   output logic              in_ready,
   output logic              load_done,
   input  idx_t              W,
   input  idx_t              J,
   output logic [COST_W-1:0] Cost,
   output logic [LB_W-1:0]   LowerBound
);

   localparam int DEPTH = ROWS * ROWS;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [COST_W-1:0] mem_q [DEPTH];
   logic              accept;

   assign in_ready  = (state_q == LOAD);
   assign load_done = (state_q == SERVE);

   // A word offered alongside clear is consumed by the handshake but dropped.
   assign accept = in_valid & in_ready & ~clear;

   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      if (clear) begin
         state_d  = LOAD;
         wr_cnt_d = '0;
      end else if (accept) begin
         wr_cnt_d = wr_cnt_q + ADDR_W'(1);
         if (wr_cnt_q == ADDR_W'(DEPTH - 1))
            state_d = SERVE;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= LOAD;
         wr_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else if (accept) begin
         mem_q[wr_cnt_q] <= in_data;
      end
   end

   assign Cost = mem_q[{W, J}];

   jam_row_min_acc u_row_min_acc (
      .CLK    (CLK),
      .RST    (RST),
      .accept (accept),
      .col    (wr_cnt_q[2:0]),
      .data   (in_data),
      .clear  (clear),
      .lb     (LowerBound)
   );

endmodule

// File: tb/tb_jam_cost_buffer.sv
// Directed self-checking bench for jam_cost_buffer.
module tb_jam_cost_buffer;
   import jam_pkg::*;

   logic              CLK = 1'b0;
   logic              RST;
   logic              clear;
   logic              in_valid;
   logic [COST_W-1:0] in_data;
   logic              in_ready;
   logic              load_done;
   idx_t              W, J;
   logic [COST_W-1:0] Cost;
   logic [LB_W-1:0]   LowerBound;

   int n_tests = 0;
   int n_fail  = 0;

   jam_cost_buffer dut (
      .CLK        (CLK),
      .RST        (RST),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .load_done  (load_done),
      .W          (W),
      .J          (J),
      .Cost       (Cost),
      .LowerBound (LowerBound)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: %0d", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_clear(input logic v, input logic [COST_W-1:0] d);
      clear    = 1'b1;
      in_valid = v;
      in_data  = d;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
   endtask

   // Streams the first n words; mode 0 = 8w+j, mode 1 = all 127.
   // gap inserts an idle cycle after each word. Returns edges until load_done.
   task automatic stream(input int n, input int mode, input bit gap, output int edges);
      edges = 0;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = (mode == 0) ? COST_W'(i) : COST_W'(127);
         tick();
         edges++;
         if (i == 62) check("load_done_before_last", load_done, 0);
         if (gap) begin
            in_valid = 1'b0;
            if (!load_done) begin
               tick();
               edges++;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      int edges;
      RST = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
      W = 3'd7; J = 3'd7;
      #22;
      RST = 1'b0;
      #1;
      // Reset state
      check("rst_in_ready", in_ready, 1);
      check("rst_load_done", load_done, 0);
      check("rst_lb", LowerBound, 0);
      check("rst_cost77", Cost, 0);

      // Full load, in_valid held high
      tick();
      stream(64, 0, 1'b0, edges);
      check("full_edges", edges, 64);
      check("full_load_done", load_done, 1);
      check("full_lb", LowerBound, 224);
      check("full_in_ready", in_ready, 0);
      W = 3'd5; J = 3'd3; #1;
      check("full_cost53", Cost, 43);
      W = 3'd7; J = 3'd7; #1;
      check("full_cost77", Cost, 63);

      // Toggled in_valid, then ignored words in SERVE
      do_clear(1'b0, '0);
      check("clr_in_ready", in_ready, 1);
      check("clr_load_done", load_done, 0);
      check("clr_lb", LowerBound, 0);
      stream(64, 0, 1'b1, edges);
      check("tog_edges", edges, 127);
      check("tog_load_done", load_done, 1);
      check("tog_lb", LowerBound, 224);
      W = 3'd5; J = 3'd3; #1;
      check("tog_cost53", Cost, 43);
      for (int p = 0; p < 10; p++) begin
         in_valid = 1'b1; in_data = 7'd127; tick();
         in_valid = 1'b0; tick();
      end
      W = 3'd0; J = 3'd0; #1;
      check("serve_cost00", Cost, 0);
      check("serve_lb", LowerBound, 224);
      check("serve_load_done", load_done, 1);

      // Partial load, clear, then all-127 matrix
      do_clear(1'b0, '0);
      stream(20, 0, 1'b0, edges);
      check("part_lb", LowerBound, 8);
      check("part_load_done", load_done, 0);
      do_clear(1'b0, '0);
      check("part_clr_lb", LowerBound, 0);
      stream(64, 1, 1'b0, edges);
      check("max_lb", LowerBound, 1016);
      check("max_load_done", load_done, 1);
      for (int a = 0; a < 64; a++) begin
         W = idx_t'(a >> 3); J = idx_t'(a & 7); #1;
         check($sformatf("max_cost_%0d", a), Cost, 127);
      end

      // Clear coincident with a handshake drops the word
      do_clear(1'b1, 7'd99);
      check("clrhs_in_ready", in_ready, 1);
      stream(64, 0, 1'b0, edges);
      W = 3'd0; J = 3'd0; #1;
      check("clrhs_cost00", Cost, 0);
      W = 3'd0; J = 3'd1; #1;
      check("clrhs_cost01", Cost, 1);
      check("clrhs_lb", LowerBound, 224);

      // Asynchronous reset mid-load
      do_clear(1'b0, '0);
      stream(30, 1, 1'b0, edges);
      check("pre_rst_lb", LowerBound, 381);
      W = 3'd0; J = 3'd1;
      #2;
      RST = 1'b1;
      #1;
      check("arst_in_ready", in_ready, 1);
      check("arst_load_done", load_done, 0);
      check("arst_lb", LowerBound, 0);
      check("arst_cost01", Cost, 0);
      @(negedge CLK);
      RST = 1'b0;
      tick();
      stream(64, 0, 1'b0, edges);
      check("post_rst_edges", edges, 64);
      check("post_rst_lb", LowerBound, 224);
      check("post_rst_load_done", load_done, 1);
      check("post_rst_in_ready", in_ready, 0);
      W = 3'd5; J = 3'd3; #1;
      check("post_rst_cost53", Cost, 43);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule
